// File: rtl/ex_lsu.sv
// ---------------------------------------------------------------------------
// ex_lsu -- execute-stage load/store unit
//
// Sits directly behind the ID/EX pipeline register. It takes the registered
// load/store codes, the ALU effective address, rs2 store data and rd. It then
// runs one data-memory transaction on a req/gnt/rvalid bus, and aligns and
// extends the returned load data. While the access is in flight it stalls the
// upstream stages through hold_n_o.
//
// Parameters
//   TIMEOUT  bus cycles spent in REQ/WAIT_R before the access is aborted
//   AW       address width
//
// Ports
//   clk, rst_n          core clock (rising edge), async active-low reset
//   load_code_i         LB=000 LH=001 LW=010 LBU=100 LHU=101 NOPE=111
//   store_code_i        SB=000 SH=001 SW=010 NOPE=111
//   addr_i              effective address
//   data_rs2_i          store data
//   addr_rd_i           load destination register
//   hold_n_o            0 = stall IF/ID and ID/EX
//   mem_req_o/we/addr/be/wdata   bus request side (valid only while req=1)
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i   bus response side
//   load_data_o         aligned/extended load result (held between loads)
//   load_valid_o        1-cycle pulse: write load_data_o to rd_addr_o
//   rd_addr_o           destination register qualifying load_valid_o
//   misalign_o          1-cycle pulse: misaligned access, no bus traffic
//   bus_err_o           1-cycle pulse: access aborted by timeout
// ---------------------------------------------------------------------------
module ex_lsu #(
  parameter int TIMEOUT = 64,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    load_code_i,
  input  logic [2:0]    store_code_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   data_rs2_i,
  input  logic [4:0]    addr_rd_i,
  output logic          hold_n_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  output logic [31:0]   load_data_o,
  output logic          load_valid_o,
  output logic [4:0]    rd_addr_o,
  output logic          misalign_o,
  output logic          bus_err_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Outcome of the access, reported during the single DONE cycle.
  localparam logic [1:0] R_LOAD  = 2'd0;
  localparam logic [1:0] R_STORE = 2'd1;
  localparam logic [1:0] R_MIS   = 2'd2;
  localparam logic [1:0] R_ERR   = 2'd3;

  localparam logic [2:0] CODE_NOPE = 3'b111;

  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT);

  logic [1:0]    state_q;
  logic          is_load_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    off_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [4:0]    rd_q;
  logic [1:0]    res_q;
  logic [CW-1:0] tcnt_q;
  logic [31:0]   load_data_q;

  // ---------------------------------------------------------------------
  // Decode of the op presented by ID/EX. When both codes are live the load
  // wins and the store is ignored. Size comes from code[1:0]
  // (00 byte, 01 half, otherwise word) and code[2] selects zero-extension.
  // ---------------------------------------------------------------------
  logic          load_sel;
  logic          op_valid;
  logic [2:0]    code;
  logic [1:0]    size;
  logic [1:0]    off;
  logic          misalign;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;

  assign load_sel = (load_code_i != CODE_NOPE);
  assign op_valid = load_sel | (store_code_i != CODE_NOPE);
  assign code     = load_sel ? load_code_i : store_code_i;
  assign size     = code[1:0];
  assign off      = addr_i[1:0];
  assign misalign = ((size == 2'b01) & off[0]) | (size[1] & (off != 2'b00));

  // Store lane placement: bytes and halves are replicated across the word so
  // the byte enables alone pick the destination lane.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    if (!load_sel) begin
      case (size)
        2'b00: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{data_rs2_i[7:0]}};
        end
        2'b01: begin
          be_d    = off[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{data_rs2_i[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = data_rs2_i;
        end
      endcase
    end
  end

  // Select the addressed byte/half of the returned word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] rdata,
                                          input logic [1:0]  sz,
                                          input logic        zext,
                                          input logic [1:0]  byte_off);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {byte_off, 3'b000};
    b       = shifted[7:0];
    h       = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      2'b00:   extract = zext ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extract = zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: extract = rdata;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Control FSM and latched transaction.
  // ---------------------------------------------------------------------
  logic timed_out;
  assign timed_out = (tcnt_q == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_load_q   <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      rd_q        <= 5'd0;
      res_q       <= R_LOAD;
      tcnt_q      <= '0;
      load_data_q <= 32'h0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so that every
      // register samples the pre-edge values, independent of statement order.
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            is_load_q <= load_sel;
            size_q    <= size;
            uns_q     <= code[2];
            off_q     <= off;
            addr_q    <= {addr_i[AW-1:2], 2'b00};
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_q      <= addr_rd_i;
            tcnt_q    <= '0;
            if (misalign) begin
              res_q   <= R_MIS;
              state_q <= S_DONE;
            end else begin
              state_q <= S_REQ;
            end
          end
        end

        // A handshake arriving in the last allowed cycle still completes.
        S_REQ: begin
          if (tcnt_q != T_MAX) tcnt_q <= tcnt_q + CW'(1);
          if (mem_gnt_i) begin
            if (is_load_q) begin
              state_q <= S_WAIT_R;
            end else begin
              res_q   <= R_STORE;
              state_q <= S_DONE;
            end
          end else if (timed_out) begin
            res_q       <= R_ERR;
            load_data_q <= 32'h0;
            state_q     <= S_DONE;
          end
        end

        S_WAIT_R: begin
          if (tcnt_q != T_MAX) tcnt_q <= tcnt_q + CW'(1);
          if (mem_rvalid_i) begin
            load_data_q <= extract(mem_rdata_i, size_q, uns_q, off_q);
            res_q       <= R_LOAD;
            state_q     <= S_DONE;
          end else if (timed_out) begin
            res_q       <= R_ERR;
            load_data_q <= 32'h0;
            state_q     <= S_DONE;
          end
        end

        default: state_q <= S_IDLE;  // S_DONE lasts exactly one cycle
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. The bus side is gated by REQ so it is quiet outside a request
  // and drops the moment reset returns the FSM to IDLE.
  // ---------------------------------------------------------------------
  logic in_req;
  logic in_done;
  assign in_req  = (state_q == S_REQ);
  assign in_done = (state_q == S_DONE);

  // rst_n masks the IDLE term so no stall is requested while in reset.
  assign hold_n_o = ~(((state_q == S_IDLE) & op_valid & rst_n) |
                      in_req | (state_q == S_WAIT_R));

  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & ~is_load_q;
  assign mem_addr_o  = in_req ? addr_q  : '0;
  assign mem_be_o    = in_req ? be_q    : 4'b0000;
  assign mem_wdata_o = in_req ? wdata_q : 32'h0;

  assign load_valid_o = in_done & (res_q == R_LOAD);
  assign rd_addr_o    = load_valid_o ? rd_q : 5'd0;
  assign misalign_o   = in_done & (res_q == R_MIS);
  assign bus_err_o    = in_done & (res_q == R_ERR);
  assign load_data_o  = load_data_q;

endmodule

// File: tb/tb_ex_lsu.sv
// ---------------------------------------------------------------------------
// tb_ex_lsu -- directed self-checking bench for ex_lsu (TIMEOUT = 4).
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked 1 time unit later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_ex_lsu;

  localparam logic [2:0] NOPE = 3'b111;

  logic        clk;
  logic        rst_n;
  logic [2:0]  load_code;
  logic [2:0]  store_code;
  logic [31:0] addr;
  logic [31:0] data_rs2;
  logic [4:0]  addr_rd;
  logic        hold_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic [4:0]  rd_addr;
  logic        misalign;
  logic        bus_err;

  int vectors     = 0;
  int miscompares = 0;
  int handshakes  = 0;

  ex_lsu #(.TIMEOUT(4), .AW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_code_i  (load_code),
    .store_code_i (store_code),
    .addr_i       (addr),
    .data_rs2_i   (data_rs2),
    .addr_rd_i    (addr_rd),
    .hold_n_o     (hold_n),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .load_data_o  (load_data),
    .load_valid_o (load_valid),
    .rd_addr_o    (rd_addr),
    .misalign_o   (misalign),
    .bus_err_o    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted bus requests, used to detect double issue.
  always @(posedge clk) if (mem_req && mem_gnt) handshakes++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Zero-wait-state load: IDLE, REQ+gnt, WAIT_R+rvalid, DONE, back to IDLE.
  task automatic do_load(input string tag, input logic [2:0] code, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [31:0] exp);
    load_code = code; addr = a; addr_rd = rd;
    settle();
    check({tag, " c0 hold_n"}, hold_n, 0);
    check({tag, " c0 req"}, mem_req, 0);
    tick(); mem_gnt = 1'b1;
    settle();
    check({tag, " c1 req"}, mem_req, 1);
    check({tag, " c1 addr"}, mem_addr, a & 32'hFFFF_FFFC);
    check({tag, " c1 be"}, mem_be, 4'b1111);
    check({tag, " c1 we"}, mem_we, 0);
    check({tag, " c1 hold_n"}, hold_n, 0);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    settle();
    check({tag, " c2 req"}, mem_req, 0);
    check({tag, " c2 hold_n"}, hold_n, 0);
    check({tag, " c2 valid"}, load_valid, 0);
    tick(); mem_rvalid = 1'b0;
    settle();
    check({tag, " c3 valid"}, load_valid, 1);
    check({tag, " c3 data"}, load_data, exp);
    check({tag, " c3 rd"}, rd_addr, rd);
    check({tag, " c3 hold_n"}, hold_n, 1);
    tick(); load_code = NOPE;
    settle();
    check({tag, " c4 valid"}, load_valid, 0);
    check({tag, " c4 data held"}, load_data, exp);
  endtask

  // Zero-wait-state store: IDLE, REQ+gnt, DONE, back to IDLE.
  task automatic do_store(input string tag, input logic [2:0] code, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    store_code = code; addr = a; data_rs2 = rs2;
    settle();
    check({tag, " c0 hold_n"}, hold_n, 0);
    tick(); mem_gnt = 1'b1;
    settle();
    check({tag, " c1 req"}, mem_req, 1);
    check({tag, " c1 we"}, mem_we, 1);
    check({tag, " c1 be"}, mem_be, exp_be);
    check({tag, " c1 wdata"}, mem_wdata, exp_wdata);
    tick(); mem_gnt = 1'b0;
    settle();
    check({tag, " c2 hold_n"}, hold_n, 1);
    check({tag, " c2 req"}, mem_req, 0);
    check({tag, " c2 valid"}, load_valid, 0);
    tick(); store_code = NOPE;
    settle();
  endtask

  // Misaligned access: IDLE, DONE with misalign_o, back to IDLE; no request.
  task automatic do_mis(input string tag, input logic [2:0] lcode, input logic [2:0] scode,
                        input logic [31:0] a);
    load_code = lcode; store_code = scode; addr = a;
    settle();
    check({tag, " c0 hold_n"}, hold_n, 0);
    check({tag, " c0 req"}, mem_req, 0);
    tick();
    check({tag, " c1 misalign"}, misalign, 1);
    check({tag, " c1 req"}, mem_req, 0);
    check({tag, " c1 hold_n"}, hold_n, 1);
    check({tag, " c1 valid"}, load_valid, 0);
    tick(); load_code = NOPE; store_code = NOPE;
    settle();
    check({tag, " c2 misalign"}, misalign, 0);
    check({tag, " c2 req"}, mem_req, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    load_code = NOPE; store_code = NOPE;
    addr = 32'h0; data_rs2 = 32'h0; addr_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // ---- reset state
    tick(); tick();
    check("rst hold_n", hold_n, 1);
    check("rst req", mem_req, 0);
    check("rst we", mem_we, 0);
    check("rst addr", mem_addr, 0);
    check("rst be", mem_be, 0);
    check("rst valid", load_valid, 0);
    check("rst data", load_data, 0);
    check("rst misalign", misalign, 0);
    check("rst bus_err", bus_err, 0);
    rst_n = 1'b1;
    tick();

    // ---- 1: LW aligned, cycle-accurate
    do_load("lw", 3'b010, 32'h0000_1000, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // ---- 2: byte/half extraction and extension
    do_load("lb3",  3'b000, 32'h0000_2003, 5'd1, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("lbu3", 3'b100, 32'h0000_2003, 5'd2, 32'h80FF_1234, 32'h0000_0080);
    do_load("lhu2", 3'b101, 32'h0000_2002, 5'd3, 32'h80FF_1234, 32'h0000_80FF);
    do_load("lh2",  3'b001, 32'h0000_2002, 5'd4, 32'h80FF_1234, 32'hFFFF_80FF);
    do_load("lb1",  3'b000, 32'h0000_2001, 5'd6, 32'h80FF_1234, 32'h0000_0012);
    do_load("lh0",  3'b001, 32'h0000_2000, 5'd7, 32'h80FF_9234, 32'hFFFF_9234);

    // Both codes live: the load executes (we=0 checked inside).
    store_code = 3'b000;
    do_load("ld+st", 3'b010, 32'h0000_9000, 5'd8, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
    store_code = NOPE;

    // ---- 3: SB with gnt low for 3 REQ cycles, granted in the 4th
    store_code = 3'b000; addr = 32'h0000_3001; data_rs2 = 32'h0000_00A5;
    settle();
    check("sb c0 hold_n", hold_n, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sb wait req", mem_req, 1);
      check("sb wait we", mem_we, 1);
      check("sb wait addr", mem_addr, 32'h0000_3000);
      check("sb wait be", mem_be, 4'b0010);
      check("sb wait wdata", mem_wdata, 32'hA5A5_A5A5);
      check("sb wait hold_n", hold_n, 0);
    end
    tick(); mem_gnt = 1'b1;
    settle();
    check("sb gnt req", mem_req, 1);
    check("sb gnt be", mem_be, 4'b0010);
    check("sb gnt bus_err", bus_err, 0);
    tick(); mem_gnt = 1'b0;
    settle();
    check("sb done hold_n", hold_n, 1);
    check("sb done req", mem_req, 0);
    check("sb done valid", load_valid, 0);
    check("sb done bus_err", bus_err, 0);
    tick(); store_code = NOPE;
    settle();
    check("sb idle valid", load_valid, 0);

    do_store("sb0", 3'b000, 32'h0000_3000, 32'h1234_5677, 4'b0001, 32'h7777_7777);
    do_store("sh2", 3'b001, 32'h0000_4002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    do_store("sh0", 3'b001, 32'h0000_4000, 32'h1234_ABCD, 4'b0011, 32'hABCD_ABCD);
    do_store("sw",  3'b010, 32'h0000_4004, 32'h1122_3344, 4'b1111, 32'h1122_3344);

    // ---- 4: misaligned accesses
    do_mis("lw mis", 3'b010, NOPE, 32'h0000_1002);
    do_mis("sh mis", NOPE, 3'b001, 32'h0000_1001);
    do_mis("lhu mis", 3'b101, NOPE, 32'h0000_1003);

    // ---- 5: LH granted, rvalid never comes -> abort after 4 bus cycles
    load_code = 3'b001; addr = 32'h0000_5000; addr_rd = 5'd10;
    settle();
    tick(); mem_gnt = 1'b1;
    settle();
    check("to req", mem_req, 1);
    tick(); mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("to wait bus_err", bus_err, 0);
      check("to wait hold_n", hold_n, 0);
      check("to wait req", mem_req, 0);
      tick();
    end
    settle();
    check("to done bus_err", bus_err, 1);
    check("to done valid", load_valid, 0);
    check("to done data", load_data, 0);
    check("to done req", mem_req, 0);
    check("to done hold_n", hold_n, 1);
    tick(); load_code = NOPE; mem_rvalid = 1'b1; mem_rdata = 32'h0000_FFFF;
    settle();
    check("to late valid", load_valid, 0);
    check("to late bus_err", bus_err, 0);
    check("to late hold_n", hold_n, 1);
    tick(); mem_rvalid = 1'b0;
    settle();
    check("to after valid", load_valid, 0);
    check("to after data", load_data, 0);

    // ---- 6a: reset while in WAIT_R
    do_load("pre", 3'b010, 32'h0000_6000, 5'd11, 32'h5555_AAAA, 32'h5555_AAAA);
    load_code = 3'b010; addr = 32'h0000_6004; addr_rd = 5'd12;
    settle();
    tick(); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0;
    settle();
    check("wr wait hold_n", hold_n, 0);
    rst_n = 1'b0;
    settle();
    check("wr rst hold_n", hold_n, 1);
    check("wr rst req", mem_req, 0);
    check("wr rst valid", load_valid, 0);
    check("wr rst data", load_data, 0);
    load_code = NOPE;
    tick(); tick();
    rst_n = 1'b1;
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
    settle();
    check("wr stray valid", load_valid, 0);
    check("wr stray hold_n", hold_n, 1);
    tick(); mem_rvalid = 1'b0;
    settle();
    check("wr stray2 valid", load_valid, 0);
    check("wr stray data", load_data, 0);

    // ---- 6b: reset while in REQ drops the request immediately
    store_code = 3'b010; addr = 32'h0000_7000; data_rs2 = 32'h0F0F_0F0F;
    settle();
    tick();
    check("rq req", mem_req, 1);
    rst_n = 1'b0;
    settle();
    check("rq rst req", mem_req, 0);
    check("rq rst we", mem_we, 0);
    check("rq rst be", mem_be, 0);
    store_code = NOPE;
    tick();
    rst_n = 1'b1;
    tick();

    // ---- 6c: back-to-back SW then LW with gnt held high throughout
    base = handshakes;
    mem_gnt = 1'b1;
    store_code = 3'b010; addr = 32'h0000_8000; data_rs2 = 32'h1122_3344;
    settle();
    check("bb sw c0 hold_n", hold_n, 0);
    tick();
    check("bb sw req", mem_req, 1);
    check("bb sw we", mem_we, 1);
    check("bb sw wdata", mem_wdata, 32'h1122_3344);
    tick();
    check("bb sw done hold_n", hold_n, 1);
    check("bb sw done req", mem_req, 0);
    tick(); store_code = NOPE; load_code = 3'b010; addr = 32'h0000_8004; addr_rd = 5'd9;
    settle();
    check("bb lw c0 hold_n", hold_n, 0);
    check("bb lw c0 req", mem_req, 0);
    tick();
    check("bb lw req", mem_req, 1);
    check("bb lw we", mem_we, 0);
    check("bb lw addr", mem_addr, 32'h0000_8004);
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    settle();
    check("bb lw wait req", mem_req, 0);
    tick(); mem_rvalid = 1'b0;
    settle();
    check("bb lw valid", load_valid, 1);
    check("bb lw data", load_data, 32'hCAFE_F00D);
    check("bb lw rd", rd_addr, 5'd9);
    tick(); load_code = NOPE; mem_gnt = 1'b0;
    tick(); tick();
    check("bb handshakes", handshakes - base, 2);
    check("bb idle req", mem_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_lsu.md
Name: ex_lsu

Overview:
Execute-stage load/store unit, directly downstream of the ID/EX pipeline register. It consumes the registered load/store codes, the effective address from the EX ALU, rs2 store data and rd. It runs a single data-memory transaction over a req/gnt/rvalid bus, aligns and extends load data, and stalls the upstream stages through hold_n_o until the access retires.

Parameters:
TIMEOUT, 64, bus cycles waited in REQ or WAIT_R before the access is aborted with bus_err_o
AW, 32, address width

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_code_i  input  3  from ID/EX; LB=000 LH=001 LW=010 LBU=100 LHU=101 `LOAD_NOPE=111
store_code_i  input  3  from ID/EX; SB=000 SH=001 SW=010 `STORE_NOPE=111
addr_i  input  AW  effective address (ALU result)
data_rs2_i  input  32  store data
addr_rd_i  input  5  load destination register
hold_n_o  output  1  0 = stall IF/ID and ID/EX (drives their hold_n)
mem_req_o  output  1  bus request
mem_we_o  output  1  1 = write
mem_addr_o  output  AW  word-aligned address ({addr[AW-1:2],2'b00})
mem_be_o  output  4  byte enables
mem_wdata_o  output  32  lane-replicated store data
mem_gnt_i  input  1  request accepted this cycle
mem_rvalid_i  input  1  read data valid
mem_rdata_i  input  32  read data
load_data_o  output  32  aligned/extended load result
load_valid_o  output  1  1-cycle pulse: write load_data_o to rd
rd_addr_o  output  5  rd for load_valid_o
misalign_o  output  1  1-cycle pulse: misaligned access, no bus traffic
bus_err_o  output  1  1-cycle pulse: timeout abort

Behaviour:
- Reset (async, any state): state=IDLE; every output 0 except hold_n_o=1 (no op present at reset). An in-flight request is dropped.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- op_valid = (load_code_i!=111)|(store_code_i!=111). If both codes are non-NOPE, the load executes and the store is ignored.
- Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
- IDLE: on op_valid, latch code, address, byte offset, write data/be and rd. Misaligned -> DONE with misalign_o. Otherwise -> REQ.
- REQ: mem_req_o=1; mem_we_o/addr/be/wdata are held stable from the latched values until the handshake. On mem_gnt_i, a store -> DONE and a load -> WAIT_R.
- WAIT_R: mem_rvalid_i captures the extracted data -> DONE. rvalid never arrives in the same cycle as gnt; rvalid outside WAIT_R is ignored.
- DONE: exactly one cycle, then -> IDLE unconditionally. Pulses asserted here:
  - load: load_valid_o=1 with rd_addr_o
  - misaligned: misalign_o=1
  - timeout: bus_err_o=1, load_valid_o=0, load_data_o=0
- hold_n_o = 0 when (IDLE & op_valid) | REQ | WAIT_R. It is 1 in DONE, so ID/EX advances on the edge that leaves DONE. The next IDLE therefore sees a new op, and there is no double issue.
- Timeout: the counter clears on entry to REQ, counts in REQ and WAIT_R, and saturates. On reaching TIMEOUT it goes to DONE with bus_err_o and drops mem_req_o.
- Store lanes:
  - SB: be=0001<<off, wdata={4{rs2[7:0]}}
  - SH: be=0011 (off=0) or 1100 (off=2), wdata={2{rs2[15:0]}}
  - SW: be=1111, wdata=rs2
- Loads: mem_we_o=0, be=1111. The byte/half is selected by the latched offset. LB/LH sign-extend; LBU/LHU zero-extend.
- Latency with zero wait states:
  - aligned load: 4 cycles (IDLE, REQ+gnt, WAIT_R+rvalid, DONE)
  - store: 3 cycles
  - misaligned: 2 cycles
- Outside DONE, load_valid_o, misalign_o and bus_err_o are 0. load_data_o holds its last value except after a timeout (0).

Test Plan:
1. LW addr 0x1000, gnt cycle 1, rvalid cycle 2 with rdata 0xDEADBEEF -> mem_addr_o=0x1000, be=1111; load_valid_o=1 in cycle 3 with data 0xDEADBEEF and rd as given; hold_n_o=0 in cycles 0-2.
2. LB addr 0x2003, rdata 0x80FF1234 -> load_data_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x2002 -> 0x000080FF.
3. SB addr 0x3001 rs2=0x000000A5 -> be=0010, wdata=0xA5A5A5A5, we=1; gnt held low 3 cycles -> req and all bus outputs stable; DONE one cycle after gnt; load_valid_o never asserted.
4. LW addr 0x1002 -> misalign_o pulse in cycle 1, mem_req_o never 1, hold_n_o low only in cycle 0; SH 0x1001 likewise.
5. TIMEOUT=4, LH with gnt but no rvalid -> bus_err_o pulse after 4 cycles, load_valid_o=0, load_data_o=0, mem_req_o=0, then IDLE; a late rvalid is ignored.
6. rst_n low while in WAIT_R -> mem_req_o=0 immediately, state IDLE, no load_valid_o; back-to-back SW then LW -> each issues exactly one bus request.
